// File: rtl/uart_tx_param.sv
// uart_tx_param: FIFO-buffered UART transmitter with built-in baud divider.
module uart_tx_param #(
  parameter int CLK_DIV    = 5208,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [DATA_BITS-1:0]          tx_data,
  input  logic                          tx_valid,
  output logic                          tx_ready,
  output logic                          serial_tx,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;
  localparam int DW = $clog2(CLK_DIV);
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PAR, S_STOP} state_t;
  state_t r_state, w_state_n;
  logic [DATA_BITS-1:0] r_mem [FIFO_DEPTH];
  logic [AW-1:0] r_wptr, r_rptr;
  logic [LW-1:0] r_level, w_level_n;
  logic r_ready, r_tx, r_par, w_par_n, w_tx_n, w_push, w_pop, w_tick, w_nonempty;
  logic [DW-1:0] r_div;
  logic [3:0] r_bit, w_bit_n;
  logic [DATA_BITS-1:0] r_shift, w_shift_n, w_head;
  assign w_push     = tx_valid && r_ready;
  assign w_nonempty = r_level != '0;
  assign w_head     = r_mem[r_rptr];
  assign w_tick     = r_div == DW'(CLK_DIV - 1);
  assign w_level_n  = r_level + LW'(w_push) - LW'(w_pop);
  assign tx_ready   = r_ready;
  assign serial_tx  = r_tx;
  assign busy       = r_state != S_IDLE;
  assign fifo_level = r_level;
  always_ff @(posedge clk)
    if (w_push) r_mem[r_wptr] <= tx_data;
  // tx_ready is registered from the post-update level so it never depends on a same-cycle pop
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_level <= '0;
      r_ready <= 1'b1;
    end else begin
      if (w_push) r_wptr <= r_wptr + AW'(1);
      if (w_pop) r_rptr <= r_rptr + AW'(1);
      r_level <= w_level_n;
      r_ready <= w_level_n != LW'(FIFO_DEPTH);
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_div   <= '0;
      r_bit   <= '0;
      r_shift <= '0;
      r_par   <= 1'b0;
      r_tx    <= 1'b1;
    end else begin
      r_state <= w_state_n;
      r_div   <= (r_state == S_IDLE || w_tick) ? '0 : r_div + DW'(1);
      r_bit   <= w_bit_n;
      r_shift <= w_shift_n;
      r_par   <= w_par_n;
      r_tx    <= w_tx_n;
    end
  end
  always_comb begin
    w_state_n = r_state;
    w_bit_n   = r_bit;
    w_shift_n = r_shift;
    w_par_n   = r_par;
    w_pop     = 1'b0;
    case (r_state)
      S_IDLE:  w_pop = w_nonempty;
      S_START: if (w_tick) w_state_n = S_DATA;
      S_DATA: if (w_tick) begin
        w_shift_n = r_shift >> 1;
        w_bit_n   = r_bit + 4'd1;
        if (r_bit == 4'(DATA_BITS - 1)) begin
          w_state_n = (PARITY != 0) ? S_PAR : S_STOP;
          w_bit_n   = '0;
        end
      end
      S_PAR:   if (w_tick) w_state_n = S_STOP;
      S_STOP: if (w_tick) begin
        w_bit_n = r_bit + 4'd1;
        if (r_bit == 4'(STOP_BITS - 1)) begin
          w_pop     = w_nonempty;
          w_state_n = S_IDLE;
          w_bit_n   = '0;
        end
      end
      default: w_state_n = S_IDLE;
    endcase
    // Loading a word always starts a fresh frame, from IDLE or straight out of STOP
    if (w_pop) begin
      w_state_n = S_START;
      w_shift_n = w_head;
      w_par_n   = (PARITY == 1) ? ~^w_head : ^w_head;
      w_bit_n   = '0;
    end
    w_tx_n = (w_state_n == S_START) ? 1'b0 :
             (w_state_n == S_DATA)  ? w_shift_n[0] :
             (w_state_n == S_PAR)   ? w_par_n : 1'b1;
  end
endmodule

// File: tb/tb_uart_tx_param.sv
// tb_uart_tx_param: directed frame vectors on 8N1, 7E2 and 7O2 instances plus FIFO and reset sequences.
module tb_uart_tx_param;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  logic [7:0] d0;
  logic [6:0] d1, d2;
  logic v0, v1, v2, tx0, tx1, tx2, rdy0, rdy1, rdy2, busy0, busy1, busy2;
  logic [2:0] lvl0, lvl1, lvl2;
  int checks = 0;
  int errors = 0;
  uart_tx_param #(.CLK_DIV(4)) dut0 (
    .clk(clk), .rst(rst), .tx_data(d0), .tx_valid(v0), .tx_ready(rdy0),
    .serial_tx(tx0), .busy(busy0), .fifo_level(lvl0));
  uart_tx_param #(.CLK_DIV(4), .DATA_BITS(7), .PARITY(2), .STOP_BITS(2)) dut1 (
    .clk(clk), .rst(rst), .tx_data(d1), .tx_valid(v1), .tx_ready(rdy1),
    .serial_tx(tx1), .busy(busy1), .fifo_level(lvl1));
  uart_tx_param #(.CLK_DIV(4), .DATA_BITS(7), .PARITY(1), .STOP_BITS(2)) dut2 (
    .clk(clk), .rst(rst), .tx_data(d2), .tx_valid(v2), .tx_ready(rdy2),
    .serial_tx(tx2), .busy(busy2), .fifo_level(lvl2));
  // e holds the frame in transmission order, first bit in e[15]
  typedef struct packed {
    logic [1:0]  s;
    logic [7:0]  d;
    logic [15:0] e;
    logic [4:0]  n;
  } vec_t;
  typedef struct packed {
    int         c;
    logic [2:0] lvl;
    logic       rdy;
  } cp_t;
  vec_t tbl [8];
  cp_t  cps [9];
  function automatic logic tx_of(input logic [1:0] s);
    return s == 2'd0 ? tx0 : s == 2'd1 ? tx1 : tx2;
  endfunction
  function automatic logic busy_of(input logic [1:0] s);
    return s == 2'd0 ? busy0 : s == 2'd1 ? busy1 : busy2;
  endfunction
  function automatic logic rdy_of(input logic [1:0] s);
    return s == 2'd0 ? rdy0 : s == 2'd1 ? rdy1 : rdy2;
  endfunction
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  task automatic send(input vec_t v);
    chk("ready_before", 32'(rdy_of(v.s)), 1);
    case (v.s)
      2'd0: begin v0 = 1'b1; d0 = v.d; end
      2'd1: begin v1 = 1'b1; d1 = v.d[6:0]; end
      default: begin v2 = 1'b1; d2 = v.d[6:0]; end
    endcase
    step();
    v0 = 1'b0; v1 = 1'b0; v2 = 1'b0;
    chk("line_at_accept", 32'(tx_of(v.s)), 1);
    for (int i = 0; i < int'(v.n) * 4; i++) begin
      step();
      if (i == 0) chk("busy_rise", 32'(busy_of(v.s)), 1);
      chk($sformatf("d%0d_%02h_bit%0d_cyc%0d", v.s, v.d, i / 4, i % 4),
          32'(tx_of(v.s)), 32'(v.e[15 - i / 4]));
    end
    step();
    chk("busy_after", 32'(busy_of(v.s)), 0);
    chk("line_after", 32'(tx_of(v.s)), 1);
  endtask
  initial begin
    logic rdy;
    int w, k, b;
    logic e;
    tbl[0] = '{2'd0, 8'hA5, {10'b0101001011, 6'd0}, 5'd10};
    tbl[1] = '{2'd0, 8'h00, {10'b0000000001, 6'd0}, 5'd10};
    tbl[2] = '{2'd0, 8'hFF, {10'b0111111111, 6'd0}, 5'd10};
    tbl[3] = '{2'd0, 8'h3C, {10'b0001111001, 6'd0}, 5'd10};
    tbl[4] = '{2'd1, 8'h55, {11'b01010101011, 5'd0}, 5'd11};
    tbl[5] = '{2'd2, 8'h55, {11'b01010101111, 5'd0}, 5'd11};
    tbl[6] = '{2'd1, 8'h07, {11'b01110000111, 5'd0}, 5'd11};
    tbl[7] = '{2'd2, 8'h07, {11'b01110000011, 5'd0}, 5'd11};
    cps[0] = '{0, 3'd1, 1'b1};
    cps[1] = '{1, 3'd1, 1'b1};
    cps[2] = '{4, 3'd4, 1'b0};
    cps[3] = '{40, 3'd4, 1'b0};
    cps[4] = '{41, 3'd3, 1'b1};
    cps[5] = '{42, 3'd4, 1'b0};
    cps[6] = '{81, 3'd3, 1'b1};
    cps[7] = '{121, 3'd2, 1'b1};
    cps[8] = '{201, 3'd0, 1'b1};
    v0 = 1'b0; v1 = 1'b0; v2 = 1'b0;
    d0 = '0; d1 = '0; d2 = '0;
    repeat (3) step();
    chk("rst_tx", 32'(tx0), 1);
    chk("rst_ready", 32'(rdy0), 1);
    chk("rst_busy", 32'(busy0), 0);
    chk("rst_level", 32'(lvl0), 0);
    chk("rst_tx_7e2", 32'(tx1), 1);
    rst = 1'b0;
    step();
    chk("idle_tx", 32'(tx0), 1);
    chk("idle_busy", 32'(busy0), 0);
    foreach (tbl[i]) send(tbl[i]);
    // six words held on tx_valid: fills the FIFO, then push/pop collide at full
    w = 1;
    v0 = 1'b1;
    d0 = 8'd1;
    for (int c = 0; c < 242; c++) begin
      rdy = rdy0;
      step();
      if (v0 && rdy) begin
        if (w == 6) v0 = 1'b0;
        else begin
          w++;
          d0 = 8'(w);
        end
      end
      chk("level_max", 32'(lvl0 <= 3'd4), 1);
      foreach (cps[j]) if (cps[j].c == c) begin
        chk($sformatf("b2b_level_c%0d", c), 32'(lvl0), 32'(cps[j].lvl));
        chk($sformatf("b2b_ready_c%0d", c), 32'(rdy0), 32'(cps[j].rdy));
      end
      if (c >= 1 && c <= 240) begin
        k = (c - 1) / 40;
        b = ((c - 1) % 40) / 4;
        e = (b == 0) ? 1'b0 : (b == 9) ? 1'b1 : 1'((k + 1) >> (b - 1));
        chk($sformatf("b2b_w%0d_bit%0d", k + 1, b), 32'(tx0), 32'(e));
      end
      if (c == 241) begin
        chk("b2b_busy_end", 32'(busy0), 0);
        chk("b2b_line_end", 32'(tx0), 1);
      end
    end
    // reset during data bit 3 of 0x11 with 0x22 and 0x33 queued
    v0 = 1'b1;
    d0 = 8'h11;
    step();
    d0 = 8'h22;
    step();
    d0 = 8'h33;
    step();
    v0 = 1'b0;
    repeat (16) step();
    chk("pre_rst_bit3", 32'(tx0), 0);
    chk("pre_rst_level", 32'(lvl0), 2);
    rst = 1'b1;
    step();
    chk("rst_mid_tx", 32'(tx0), 1);
    chk("rst_mid_level", 32'(lvl0), 0);
    chk("rst_mid_busy", 32'(busy0), 0);
    chk("rst_mid_ready", 32'(rdy0), 1);
    rst = 1'b0;
    repeat (6) begin
      step();
      chk("post_rst_quiet", 32'({busy0, tx0}), 32'b01);
    end
    send(tbl[3]);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
